// File: rtl/aidc_lite_decomp_engine_pkg.sv
// ============================================================================
// Module : aidc_lite_decomp_engine_pkg
// Desc   : Shared AIDC_LITE constants: AHB encodings, engine states, address helpers
// Rev    : 1.0
// ============================================================================
`default_nettype none

package aidc_lite_decomp_engine_pkg;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_BUSY   = 2'b01,
      HTRANS_NONSEQ = 2'b10,
      HTRANS_SEQ    = 2'b11
   } htrans_e;

   localparam logic [2:0] HSIZE_WORD   = 3'b010;
   localparam logic [2:0] HBURST_INCR16 = 3'b111;
   localparam logic [3:0] HPROT_DATA   = 4'b0001;

   typedef logic [3:0] state_t;

   localparam state_t IDLE          = 4'd0;
   localparam state_t RD_BUSREQ     = 4'd1;
   localparam state_t RD_1ST_ADDR   = 4'd2;
   localparam state_t RD_MIDDLE     = 4'd3;
   localparam state_t RD_LAST_DATA  = 4'd4;
   localparam state_t DECOMP        = 4'd5;
   localparam state_t WR1_BUSREQ    = 4'd6;
   localparam state_t WR1_1ST_ADDR  = 4'd7;
   localparam state_t WR1_MIDDLE    = 4'd8;
   localparam state_t WR1_LAST_DATA = 4'd9;
   localparam state_t WR2_BUSREQ    = 4'd10;
   localparam state_t WR2_1ST_ADDR  = 4'd11;
   localparam state_t WR2_MIDDLE    = 4'd12;
   localparam state_t WR2_LAST_DATA = 4'd13;

   // A block is 64B compressed and 128B decompressed.
   function automatic logic [31:0] rd_blk_addr(input logic [31:0] base, input logic [24:0] blk);
      return base + {1'b0, blk, 6'd0};
   endfunction

   function automatic logic [31:0] wr_blk_addr(input logic [31:0] base, input logic [24:0] blk);
      return base + {blk, 7'd0};
   endfunction

endpackage

`default_nettype wire

// File: rtl/aidc_lite_decomp_engine_if.sv
// ============================================================================
// Module : AHB2_MST_INTF
// Desc   : AHB2 master-side bus bundle (arbitration, address, data, response)
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface AHB2_MST_INTF;
   logic        hbusreq;
   logic        hgrant;
   logic [31:0] haddr;
   logic [1:0]  htrans;
   logic        hwrite;
   logic [2:0]  hsize;
   logic [2:0]  hburst;
   logic [3:0]  hprot;
   logic [31:0] hwdata;
   logic [31:0] hrdata;
   logic        hready;

   modport master (
      output hbusreq, haddr, htrans, hwrite, hsize, hburst, hprot, hwdata,
      input  hgrant, hrdata, hready
   );

   modport slave (
      input  hbusreq, haddr, htrans, hwrite, hsize, hburst, hprot, hwdata,
      output hgrant, hrdata, hready
   );
endinterface

`default_nettype wire

// File: rtl/aidc_lite_decomp_engine.sv
// ============================================================================
// Module : aidc_lite_decomp_engine
// Desc   : Streams 64B compressed blocks over AHB into a decompressor and writes
//          the 128B result back as two INCR16 write bursts per block.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module aidc_lite_decomp_engine
   import aidc_lite_decomp_engine_pkg::*;
(
   input  wire logic        clk,
   input  wire logic        rst,
   input  wire logic [31:0] src_addr_i,
   input  wire logic [31:0] dst_addr_i,
   input  wire logic [31:7] len_i,
   input  wire logic        start_i,
   output logic             done_o,
   AHB2_MST_INTF.master     ahb_if,
   output logic             decomp_wren_o,
   output logic             decomp_sop_o,
   output logic             decomp_eop_o,
   output logic [31:0]      decomp_wdata_o,
   input  wire logic        decomp_ready_i,
   output logic             decomp_rden_o,
   input  wire logic [63:0] decomp_rdata_i
);

   state_t      r_state;
   logic [24:0] r_blk_cnt;
   logic [4:0]  r_beat_cnt;
   logic        r_hbusreq;
   logic [31:0] r_haddr;
   logic [1:0]  r_htrans;
   logic        r_hwrite;
   logic        r_wren;
   logic        r_sop;
   logic        r_eop;
   logic [31:0] r_wdata;

   logic        w_rd_beat;
   logic        w_wr_beat;
   logic        w_mid_last;
   logic [24:0] w_blk_nxt;

   assign w_rd_beat = ahb_if.hready &&
                      ((r_state == RD_MIDDLE) || (r_state == RD_LAST_DATA));
   assign w_wr_beat = ahb_if.hready &&
                      ((r_state == WR1_MIDDLE) || (r_state == WR1_LAST_DATA) ||
                       (r_state == WR2_MIDDLE) || (r_state == WR2_LAST_DATA));
   // WR2 continues the beat count from WR1, so its final middle beat is 30.
   assign w_mid_last = (r_state == WR2_MIDDLE) ? (r_beat_cnt == 5'd30) : (r_beat_cnt == 5'd14);
   assign w_blk_nxt  = r_blk_cnt + 25'd1;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_blk_cnt  <= '0;
         r_beat_cnt <= '0;
         r_hbusreq  <= 1'b0;
         r_haddr    <= '0;
         r_htrans   <= HTRANS_IDLE;
         r_hwrite   <= 1'b0;
         r_wren     <= 1'b0;
         r_sop      <= 1'b0;
         r_eop      <= 1'b0;
         r_wdata    <= '0;
      end else begin
         r_wren <= w_rd_beat;
         r_sop  <= w_rd_beat && (r_beat_cnt == 5'd0);
         r_eop  <= w_rd_beat && (r_beat_cnt == 5'd15);
         if (w_rd_beat) begin
            r_wdata <= ahb_if.hrdata;
         end

         case (r_state)
            IDLE: begin
               if (start_i && (len_i != '0)) begin
                  r_blk_cnt <= '0;
                  r_hbusreq <= 1'b1;
                  r_state   <= RD_BUSREQ;
               end
            end
            RD_BUSREQ: begin
               if (ahb_if.hgrant) begin
                  r_hbusreq <= 1'b0;
                  r_htrans  <= HTRANS_NONSEQ;
                  r_haddr   <= rd_blk_addr(src_addr_i, r_blk_cnt);
                  r_hwrite  <= 1'b0;
                  r_state   <= RD_1ST_ADDR;
               end
            end
            WR1_BUSREQ: begin
               if (ahb_if.hgrant) begin
                  r_hbusreq <= 1'b0;
                  r_htrans  <= HTRANS_NONSEQ;
                  r_haddr   <= wr_blk_addr(dst_addr_i, r_blk_cnt);
                  r_hwrite  <= 1'b1;
                  r_state   <= WR1_1ST_ADDR;
               end
            end
            WR2_BUSREQ: begin
               if (ahb_if.hgrant) begin
                  r_hbusreq <= 1'b0;
                  r_htrans  <= HTRANS_NONSEQ;
                  r_state   <= WR2_1ST_ADDR;
               end
            end
            RD_1ST_ADDR, WR1_1ST_ADDR, WR2_1ST_ADDR: begin
               if (ahb_if.hready) begin
                  r_haddr  <= r_haddr + 32'd4;
                  r_htrans <= HTRANS_SEQ;
                  if (r_state != WR2_1ST_ADDR) begin
                     r_beat_cnt <= '0;
                  end
                  r_state <= (r_state == RD_1ST_ADDR)  ? RD_MIDDLE  :
                             (r_state == WR1_1ST_ADDR) ? WR1_MIDDLE : WR2_MIDDLE;
               end
            end
            RD_MIDDLE, WR1_MIDDLE, WR2_MIDDLE: begin
               if (ahb_if.hready) begin
                  r_haddr    <= r_haddr + 32'd4;
                  r_beat_cnt <= r_beat_cnt + 5'd1;
                  if (w_mid_last) begin
                     r_htrans <= HTRANS_IDLE;
                     r_state  <= (r_state == RD_MIDDLE)  ? RD_LAST_DATA  :
                                 (r_state == WR1_MIDDLE) ? WR1_LAST_DATA : WR2_LAST_DATA;
                  end
               end
            end
            RD_LAST_DATA: begin
               if (ahb_if.hready) begin
                  r_beat_cnt <= r_beat_cnt + 5'd1;
                  r_state    <= DECOMP;
               end
            end
            DECOMP: begin
               if (decomp_ready_i) begin
                  r_hbusreq <= 1'b1;
                  r_state   <= WR1_BUSREQ;
               end
            end
            WR1_LAST_DATA: begin
               if (ahb_if.hready) begin
                  r_beat_cnt <= r_beat_cnt + 5'd1;
                  r_hbusreq  <= 1'b1;
                  r_state    <= WR2_BUSREQ;
               end
            end
            WR2_LAST_DATA: begin
               if (ahb_if.hready) begin
                  r_beat_cnt <= r_beat_cnt + 5'd1;
                  r_blk_cnt  <= w_blk_nxt;
                  if (w_blk_nxt == len_i) begin
                     r_state <= IDLE;
                  end else begin
                     r_hbusreq <= 1'b1;
                     r_state   <= RD_BUSREQ;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // Each 64-bit decompressor word feeds two write beats, high half first.
   assign ahb_if.hwdata  = r_beat_cnt[0] ? decomp_rdata_i[31:0] : decomp_rdata_i[63:32];
   assign decomp_rden_o  = !rst && w_wr_beat && r_beat_cnt[0];

   assign ahb_if.hbusreq = r_hbusreq;
   assign ahb_if.haddr   = r_haddr;
   assign ahb_if.htrans  = r_htrans;
   assign ahb_if.hwrite  = r_hwrite;
   assign ahb_if.hsize   = HSIZE_WORD;
   assign ahb_if.hburst  = HBURST_INCR16;
   assign ahb_if.hprot   = HPROT_DATA;

   assign decomp_wren_o  = r_wren;
   assign decomp_sop_o   = r_sop;
   assign decomp_eop_o   = r_eop;
   assign decomp_wdata_o = r_wdata;
   assign done_o         = (r_state == IDLE) && !start_i;

endmodule

`default_nettype wire

// File: tb/tb_aidc_lite_decomp_engine.sv
// ============================================================================
// Module : tb_aidc_lite_decomp_engine
// Desc   : Bench with AHB slave/arbiter and decompressor models plus block-level reference
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_aidc_lite_decomp_engine;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] src_addr, dst_addr;
   logic [31:7] len;
   logic        start;
   logic        done;
   logic        wren, sop, eop, ready, rden;
   logic [31:0] wdata;
   logic [63:0] rdata;

   int n_vec = 0;
   int n_err = 0;

   AHB2_MST_INTF bus ();

   aidc_lite_decomp_engine dut (
      .clk            (clk),
      .rst            (rst),
      .src_addr_i     (src_addr),
      .dst_addr_i     (dst_addr),
      .len_i          (len),
      .start_i        (start),
      .done_o         (done),
      .ahb_if         (bus),
      .decomp_wren_o  (wren),
      .decomp_sop_o   (sop),
      .decomp_eop_o   (eop),
      .decomp_wdata_o (wdata),
      .decomp_ready_i (ready),
      .decomp_rden_o  (rden),
      .decomp_rdata_i (rdata)
   );

   always #5 clk = ~clk;

   // ---------------- environment state ----------------
   logic [31:0] seed = 32'h1234_5678;
   bit          cmode = 1'b0;
   bit          stall = 1'b0;
   int          gdly  = 0;
   int          gcnt  = 0;

   logic        dp_valid, dp_write;
   logic [31:0] dp_addr;
   logic [31:0] rd_q[$];
   logic [63:0] wr_q[$];
   logic [33:0] wq[$];
   int          rden_cnt = 0, rden_bad = 0, stab_viol = 0, busreq_cnt = 0;

   logic        hold, p_wdv;
   logic [31:0] p_addr, p_wd;
   logic [1:0]  p_trans;

   logic [31:0] in_mem [16];
   logic [63:0] out_mem [16];
   logic [3:0]  in_idx, rd_ptr;
   int          avail, dly;

   function automatic logic [31:0] pat(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ seed;
   endfunction

   assign bus.hrdata = (dp_valid && !dp_write) ? pat(dp_addr) : 32'hDEAD_BEEF;
   assign rdata      = out_mem[rd_ptr];
   assign ready      = (avail != 0);

   // Arbiter with programmable grant latency plus random wait-state insertion.
   always @(negedge clk) begin
      if (bus.hbusreq) begin
         gcnt++;
         bus.hgrant = (gcnt > gdly);
      end else begin
         gcnt = 0;
         bus.hgrant = 1'b0;
      end
      bus.hready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
   end

   // AHB slave: completes data phases, logs transfers, watches stall stability.
   always @(posedge clk) begin
      if (rst) begin
         dp_valid <= 1'b0;
         dp_write <= 1'b0;
         dp_addr  <= '0;
         hold     <= 1'b0;
      end else begin
         if (hold && ((bus.haddr !== p_addr) || (bus.htrans !== p_trans) ||
                      (p_wdv && (bus.hwdata !== p_wd))))
            stab_viol++;
         hold    <= !bus.hready && ((bus.htrans != 2'b00) || (dp_valid && dp_write));
         p_addr  <= bus.haddr;
         p_trans <= bus.htrans;
         p_wdv   <= dp_valid && dp_write;
         p_wd    <= bus.hwdata;
         if (rden && !(bus.hready && dp_valid && dp_write && (wr_q.size() % 2 == 1)))
            rden_bad++;
         if (bus.hbusreq) busreq_cnt++;
         if (bus.hready) begin
            if (dp_valid) begin
               if (dp_write) wr_q.push_back({dp_addr, bus.hwdata});
               else          rd_q.push_back(dp_addr);
            end
            dp_valid <= bus.htrans[1];
            dp_addr  <= bus.haddr;
            dp_write <= bus.hwrite;
         end
      end
   end

   // Decompressor: 16 words in, after a short latency 16 64-bit words out.
   always @(posedge clk) begin
      if (rst) begin
         in_idx <= '0;
         rd_ptr <= '0;
         avail  <= 0;
         dly    <= 0;
      end else begin
         if (wren) begin
            in_mem[in_idx] <= wdata;
            in_idx <= in_idx + 4'd1;
            wq.push_back({sop, eop, wdata});
            if (eop) dly <= $urandom_range(1, 4);
         end else if (dly == 1) begin
            for (int i = 0; i < 16; i++)
               out_mem[i] <= cmode ? 64'hAAAA_BBBB_CCCC_DDDD : {in_mem[i], ~in_mem[i]};
            avail  <= 16;
            rd_ptr <= '0;
            dly    <= 0;
         end else if (dly > 1) begin
            dly <= dly - 1;
         end
         if (rden) begin
            rd_ptr <= rd_ptr + 4'd1;
            avail  <= avail - 1;
            rden_cnt++;
         end
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_logs();
      rd_q.delete();
      wr_q.delete();
      wq.delete();
      rden_cnt = 0; rden_bad = 0; stab_viol = 0; busreq_cnt = 0;
   endtask

   // Launch one job and compare every bus/decompressor transfer with the block model.
   task automatic run_job(input int nblk, input logic [31:0] src, input logic [31:0] dst,
                          input bit cm, input bit st, input int gd);
      int          cyc;
      logic [31:0] a, w, ed;
      @(negedge clk);
      clear_logs();
      seed = $urandom;
      cmode = cm; stall = st; gdly = gd;
      src_addr = src; dst_addr = dst; len = 25'(nblk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 0;
      while (!done && cyc < 20000) begin
         @(negedge clk);
         cyc++;
      end
      chk("done_seen", 64'(done), 64'd1);
      chk("wr_beats_at_done", 64'(wr_q.size()), 64'(32 * nblk));
      chk("rd_beats", 64'(rd_q.size()), 64'(16 * nblk));
      chk("wren_count", 64'(wq.size()), 64'(16 * nblk));
      for (int n = 0; n < nblk; n++) begin
         for (int k = 0; k < 16; k++) begin
            a = src + 32'(n * 64 + 4 * k);
            chk("rd_addr", (n * 16 + k < rd_q.size()) ? 64'(rd_q[n * 16 + k]) : 64'hx, 64'(a));
            chk("wren_word", (n * 16 + k < wq.size()) ? 64'(wq[n * 16 + k]) : 64'hx,
                64'({(k == 0), (k == 15), pat(a)}));
         end
         for (int j = 0; j < 32; j++) begin
            w  = pat(src + 32'(n * 64 + 4 * (j / 2)));
            ed = cm ? ((j % 2 == 0) ? 32'hAAAA_BBBB : 32'hCCCC_DDDD)
                    : ((j % 2 == 0) ? w : ~w);
            chk("wr_beat", (n * 32 + j < wr_q.size()) ? wr_q[n * 32 + j] : 64'hx,
                {dst + 32'(n * 128 + 4 * j), ed});
         end
      end
      chk("rden_pulses", 64'(rden_cnt), 64'(16 * nblk));
      chk("rden_on_odd_beat", 64'(rden_bad), 64'd0);
      chk("stall_stability", 64'(stab_viol), 64'd0);
      stall = 1'b0;
   endtask

   initial begin
      int cyc;
      rst = 1'b1; start = 1'b0; len = '0; src_addr = '0; dst_addr = '0;
      repeat (3) @(negedge clk);
      chk("rst_done", 64'(done), 64'd1);
      chk("rst_hbusreq", 64'(bus.hbusreq), 64'd0);
      chk("rst_htrans", 64'(bus.htrans), 64'd0);
      chk("rst_haddr", 64'(bus.haddr), 64'd0);
      chk("rst_hwrite", 64'(bus.hwrite), 64'd0);
      chk("rst_wren", 64'({wren, sop, eop, wdata}), 64'd0);
      chk("rst_rden", 64'(rden), 64'd0);
      chk("ctrl_const", 64'({bus.hsize, bus.hburst, bus.hprot}), 64'({3'b010, 3'b111, 4'b0001}));
      rst = 1'b0;

      // Single block, zero-wait bus.
      run_job(1, 32'h0000_1000, 32'h0000_8000, 1'b0, 1'b0, 0);
      // Fixed decompressor output word splits high-then-low.
      run_job(1, 32'h0002_0000, 32'h0004_0000, 1'b1, 1'b0, 0);
      // Three blocks: block 2 at src+0x80 / dst+0x100.
      run_job(3, {$urandom_range(0, 255), 8'h00} << 8, {$urandom_range(256, 511), 8'h00} << 8,
              1'b0, 1'b0, 0);
      // Wait states and delayed grant.
      run_job(2, 32'h0010_0040, 32'h0020_0080, 1'b0, 1'b1, 5);
      for (int r = 0; r < 2; r++)
         run_job($urandom_range(1, 3), 32'($urandom) & 32'hFFFF_FFC0, 32'($urandom) & 32'hFFFF_FF80,
                 1'($urandom_range(0, 1)), 1'b1, $urandom_range(0, 4));

      // Zero-length start is ignored.
      @(negedge clk);
      clear_logs();
      len = '0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
      chk("len0_busreq", 64'(busreq_cnt), 64'd0);
      chk("len0_done", 64'(done), 64'd1);
      chk("len0_no_reads", 64'(rd_q.size()), 64'd0);

      // Reset in the middle of the first write burst, then a clean job.
      clear_logs();
      len = 25'd2; src_addr = 32'h0000_3000; dst_addr = 32'h0000_9000;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 0;
      while (wr_q.size() < 5 && cyc < 2000) begin
         @(negedge clk);
         cyc++;
      end
      chk("reached_wr1", 64'(wr_q.size()), 64'd5);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_htrans", 64'(bus.htrans), 64'd0);
      chk("midrst_hbusreq", 64'(bus.hbusreq), 64'd0);
      chk("midrst_done", 64'(done), 64'd1);
      chk("midrst_rden", 64'({rden, wren}), 64'd0);
      rst = 1'b0;
      run_job(1, 32'h0000_5000, 32'h0000_A000, 1'b0, 1'b1, 2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire

// File: doc/aidc_lite_decomp_engine.md
AIDC_LITE_DECOMP_ENGINE -- requirements
Module: AIDC_LITE_DECOMP_ENGINE

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all logic on posedge clk.
REQ-002 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-003 SHALL have ports src_addr_i and dst_addr_i, input, 32 each: compressed source base and decompressed destination base.
REQ-004 SHALL have port len_i, input, [31:7], block count; 1 block = 64B compressed in, 128B decompressed out.
REQ-005 SHALL have ports start_i (input, 1, pulse) and done_o (output, 1, level).
REQ-006 SHALL have port ahb_if, AHB2_MST_INTF.master, with hwdata driven by this block.
REQ-007 SHALL have decompressor-input ports decomp_wren_o (1), decomp_sop_o (1), decomp_eop_o (1) and decomp_wdata_o (32), all outputs.
REQ-008 SHALL have decompressor-output ports decomp_ready_i (input, 1, block decompressed), decomp_rden_o (output, 1, pop) and decomp_rdata_i (input, 64, show-ahead head word).

Function
REQ-009 SHALL use FSM states IDLE, RD_BUSREQ, RD_1ST_ADDR, RD_MIDDLE, RD_LAST_DATA, DECOMP, WR1_BUSREQ, WR1_1ST_ADDR, WR1_MIDDLE, WR1_LAST_DATA, WR2_BUSREQ, WR2_1ST_ADDR, WR2_MIDDLE and WR2_LAST_DATA.
REQ-010 SHALL, in IDLE with start_i=1 and len_i!=0, clear blk_cnt, register hbusreq=1 and go to RD_BUSREQ; with len_i=0, SHALL ignore start_i.
REQ-011 SHALL advance each *_BUSREQ state only on hgrant: deassert hbusreq, set htrans=NONSEQ, then enter the matching *_1ST_ADDR state.
REQ-012 SHALL, in RD_BUSREQ, load haddr=src_addr_i+{blk_cnt,6'd0} with hwrite=0.
REQ-013 SHALL, in WR1_BUSREQ, load haddr=dst_addr_i+{blk_cnt,7'd0} with hwrite=1; WR2 continues haddr and hwrite unchanged.
REQ-014 SHALL, in *_1ST_ADDR on hready: set haddr+=4 and htrans=SEQ, and go to *_MIDDLE; RD_1ST_ADDR and WR1_1ST_ADDR also clear beat_cnt (5 bit).
REQ-015 SHALL, in *_MIDDLE on hready: set haddr+=4, accept one data beat and beat_cnt+=1; at beat_cnt 14 (RD, WR1) or 30 (WR2), set htrans=IDLE and go to *_LAST_DATA.
REQ-016 SHALL, in *_LAST_DATA on hready: accept the final beat and beat_cnt+=1. RD then goes to DECOMP; WR1 sets hbusreq=1 and goes to WR2_BUSREQ.
REQ-017 SHALL, when a read beat k (0..15) is accepted, drive decomp_wren_o=1 next cycle with decomp_wdata_o=hrdata, decomp_sop_o=(k==0) and decomp_eop_o=(k==15); wren is 0 otherwise.
REQ-018 SHALL, in DECOMP, wait for decomp_ready_i, then set hbusreq=1 and go to WR1_BUSREQ.
REQ-019 SHALL drive hwdata combinationally during each write data phase: decomp_rdata_i[63:32] when beat_cnt[0]=0 and [31:0] when beat_cnt[0]=1.
REQ-020 SHALL assert decomp_rden_o for exactly one cycle when an odd write beat completes (hready=1), giving 16 pops per block.
REQ-021 SHALL, in WR2_LAST_DATA on hready, increment blk_cnt; if the new blk_cnt==len_i it goes to IDLE, else it sets hbusreq=1 and goes to RD_BUSREQ.
REQ-022 SHALL hold haddr, htrans and hwdata stable while hready=0.
REQ-023 SHALL drive constant hsize=3'b010, hburst=3'b111 (INCR16) and hprot=4'b0001.
REQ-024 SHALL drive done_o=(state==IDLE)&!start_i; start_i outside IDLE is ignored.
REQ-025 SHALL give blk_cnt 25 bits, with no wrap before len_i; len_i=2^25-1 is legal.

Reset
REQ-026 SHALL, with rst=1, set state=IDLE, blk_cnt=0, beat_cnt=0, hbusreq=0, haddr=0, htrans=IDLE, hwrite=0, decomp_wren_o=0 and decomp_rden_o=0; sop, eop and wdata are 0.
REQ-027 SHALL, on rst mid-transfer, abandon the burst and return to IDLE in the next cycle, with done_o=1 if start_i=0.

Structure
REQ-028 SHALL import HTRANS_* constants and the state enum type from the shared AIDC_LITE package; burst and size constants also live there.
REQ-029 SHALL be one module with no sub-modules.

Verification
REQ-030 SHALL cover: len_i=1, src=0x1000, dst=0x8000, zero-wait AHB -> reads 0x1000..0x103C, 16 decomp_wren_o with sop at beat 0 and eop at beat 15, writes 0x8000..0x807C, 16 rden pulses, done_o=1.
REQ-031 SHALL cover: len_i=3 -> block 2 reads at src+0x80 and writes at dst+0x100; done_o is high only after the 96th write beat.
REQ-032 SHALL cover: random hready low and hgrant delayed 5 cycles -> address and hwdata stable across stalls; no duplicated or dropped beats.
REQ-033 SHALL cover: decomp_rdata_i=0xAAAA_BBBB_CCCC_DDDD -> hwdata 0xAAAABBBB then 0xCCCCDDDD, with rden after the second beat.
REQ-034 SHALL cover: start_i with len_i=0 -> state remains IDLE and hbusreq is never asserted.
REQ-035 SHALL cover: rst asserted during WR1_MIDDLE -> next cycle htrans=IDLE, hbusreq=0 and state=IDLE; a fresh start_i completes correctly.
